// File: rtl/push_irq_ctrl.sv
// push_irq_ctrl: shares one CPU interrupt line among NUM_SRC debounced
// push-button sources. Rising edges latch as pending, enabled pending
// sources are granted round-robin, irq holds until acknowledged, then a
// holdoff window runs before the next grant. LEDs show the last serviced id.
module push_irq_ctrl #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2,
  parameter int HOLDOFF = 8
) (
  input  logic               S_AXI_ACLK,
  input  logic               S_AXI_ARESET,
  input  logic [NUM_SRC-1:0] intr_src,
  input  logic [NUM_SRC-1:0] mask,
  input  logic               irq_ack,
  input  logic               ovf_clr,
  output logic               irq,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] overflow,
  output logic [3:0]         led_on
);

  localparam int unsigned N = NUM_SRC;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic               irq_q, irq_d;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [3:0]         led_q, led_d;
  logic [NUM_SRC-1:0] prev_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] overflow_q, overflow_d;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] cand;
  logic [NUM_SRC-1:0] ack_vec;
  logic               ack_fire;
  logic               found;
  logic [ID_W-1:0]    pick_id;
  logic [3:0]         led_onehot;
  int unsigned        idx;

  // Edge detect, ack decode, round-robin pick and LED decode
  always_comb begin
    rise       = intr_src & ~prev_q;
    cand       = pending_q & mask;
    ack_fire   = (state_q == S_ASSERT) && irq_ack;
    ack_vec    = '0;
    if (ack_fire) begin
      ack_vec[irq_id_q] = 1'b1;
    end
    // Search upward starting one past the last serviced source, wrapping.
    found   = 1'b0;
    pick_id = '0;
    idx     = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(ptr_q) + k) % N;
      if (!found && cand[idx[ID_W-1:0]]) begin
        found   = 1'b1;
        pick_id = idx[ID_W-1:0];
      end
    end
    // Ids above 3 have no LED and light nothing.
    led_onehot = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      led_onehot[j] = (32'(irq_id_q) == j);
    end
  end

  // Pending / overflow next state; a re-arm on the ack cycle keeps pending set
  always_comb begin
    pending_d  = (pending_q & ~ack_vec) | rise;
    overflow_d = ovf_clr ? '0 : (overflow_q | (rise & pending_q & ~ack_vec));
  end

  // Grant FSM next state and registered outputs
  always_comb begin
    state_d  = state_q;
    irq_d    = irq_q;
    irq_id_d = irq_id_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    led_d    = led_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          irq_d    = 1'b1;
          irq_id_d = pick_id;
          state_d  = S_ASSERT;
        end
      end
      S_ASSERT: begin
        if (irq_ack) begin
          ptr_d   = irq_id_q;
          led_d   = led_onehot;
          irq_d   = 1'b0;
          cnt_d   = 8'(HOLDOFF);
          state_d = (HOLDOFF == 0) ? S_IDLE : S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_q <= 8'd1) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_q    <= S_IDLE;
      irq_q      <= 1'b0;
      irq_id_q   <= '0;
      ptr_q      <= ID_W'(N - 1);
      cnt_q      <= '0;
      led_q      <= '0;
      prev_q     <= '1;
      pending_q  <= '0;
      overflow_q <= '0;
    end else begin
      state_q    <= state_d;
      irq_q      <= irq_d;
      irq_id_q   <= irq_id_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      led_q      <= led_d;
      prev_q     <= intr_src;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign irq      = irq_q;
  assign irq_id   = irq_id_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;
  assign led_on   = led_q;

endmodule

// File: tb/tb_push_irq_ctrl.sv
// Bench for push_irq_ctrl: a time-based behavioural model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_push_irq_ctrl;

  localparam int N  = 4;
  localparam int HO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] src;
  logic [3:0] mask;
  logic       ack;
  logic       ovf_clr;
  logic       irq;
  logic [1:0] irq_id;
  logic [3:0] pending;
  logic [3:0] overflow;
  logic [3:0] led_on;

  int tests = 0;
  int fails = 0;

  push_irq_ctrl #(.NUM_SRC(N), .ID_W(2), .HOLDOFF(HO)) dut (
    .S_AXI_ACLK  (clk),
    .S_AXI_ARESET(rst),
    .intr_src    (src),
    .mask        (mask),
    .irq_ack     (ack),
    .ovf_clr     (ovf_clr),
    .irq         (irq),
    .irq_id      (irq_id),
    .pending     (pending),
    .overflow    (overflow),
    .led_on      (led_on)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: grants are allowed from a cycle number onward rather than a counter.
  int       cyc = 0;
  bit [3:0] m_prev = '1;
  bit [3:0] m_pend = '0;
  bit [3:0] m_ovf  = '0;
  bit       m_irq  = 1'b0;
  int       m_id   = 0;
  int       m_last = N - 1;
  bit [3:0] m_led  = '0;
  int       m_ready = 0;

  always @(posedge clk) begin
    bit [3:0] rise, clr, c;
    bit       got;
    cyc++;
    if (rst) begin
      m_prev = '1; m_pend = '0; m_ovf = '0; m_irq = 1'b0;
      m_id = 0; m_last = N - 1; m_led = '0; m_ready = 0;
    end else begin
      rise   = src & ~m_prev;
      m_prev = src;
      clr    = '0;
      if (m_irq && ack) begin
        clr     = 4'(1 << m_id);
        m_last  = m_id;
        m_led   = (m_id < 4) ? 4'(1 << m_id) : 4'b0;
        m_irq   = 1'b0;
        m_ready = cyc + HO + 1;
      end else if (!m_irq && cyc >= m_ready) begin
        c   = m_pend & mask;
        got = 1'b0;
        for (int k = 1; k <= N; k++) begin
          if (!got && c[(m_last + k) % N]) begin
            got   = 1'b1;
            m_id  = (m_last + k) % N;
            m_irq = 1'b1;
          end
        end
      end
      m_ovf  = ovf_clr ? 4'b0 : (m_ovf | (rise & m_pend & ~clr));
      m_pend = (m_pend & ~clr) | rise;
    end
  end

  // Per-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    if (cyc > 0) begin
      chk("irq", 32'(irq), 32'(m_irq));
      if (m_irq) chk("irq_id", 32'(irq_id), 32'(m_id));
      chk("pending", 32'(pending), 32'(m_pend));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("led_on", 32'(led_on), 32'(m_led));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_irq(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!irq && n < 60);
    if (!irq) chk("irq_timeout", 32'(irq), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
  endtask

  initial begin
    int n;
    rst = 1'b1; src = '0; mask = 4'hF; ack = 1'b0; ovf_clr = 1'b0;
    repeat (3) step();
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_id", 32'(irq_id), 32'd0);
    chk("rst_pend", 32'(pending), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_led", 32'(led_on), 32'd0);
    rst = 1'b0;
    repeat (2) step();

    // Single pulse on source 2
    src = 4'b0100; step();
    chk("t1_pend", 32'(pending), 32'h4);
    chk("t1_noirq", 32'(irq), 32'd0);
    src = 4'b0000; step();
    chk("t1_irq", 32'(irq), 32'd1);
    chk("t1_id", 32'(irq_id), 32'd2);
    ack = 1'b1; step(); ack = 1'b0;
    chk("t1_ackirq", 32'(irq), 32'd0);
    chk("t1_ackpend", 32'(pending), 32'd0);
    chk("t1_led", 32'(led_on), 32'h4);
    repeat (10) step();

    // All four at once: order 0..3, 9 cycles from each ack to next grant
    do_reset();
    src = 4'hF; step();
    chk("t2_pend", 32'(pending), 32'hF);
    src = 4'h0;
    for (int g = 0; g < 4; g++) begin
      wait_irq(n);
      chk("t2_gap", 32'(n), (g == 0) ? 32'd1 : 32'd9);
      chk("t2_id", 32'(irq_id), 32'(g));
      ack = 1'b1; step(); ack = 1'b0;
    end
    chk("t2_led", 32'(led_on), 32'h8);
    repeat (10) step();

    // Masked pending source waits until enabled
    do_reset();
    mask = 4'b0001;
    src = 4'b0011; step();
    src = 4'b0000; step();
    chk("t3_irq", 32'(irq), 32'd1);
    chk("t3_id", 32'(irq_id), 32'd0);
    ack = 1'b1; step(); ack = 1'b0;
    chk("t3_pend", 32'(pending), 32'h2);
    repeat (12) step();
    chk("t3_held", 32'(irq), 32'd0);
    chk("t3_pend2", 32'(pending), 32'h2);
    mask = 4'b0011; step();
    chk("t3_irq1", 32'(irq), 32'd1);
    chk("t3_id1", 32'(irq_id), 32'd1);
    ack = 1'b1; step(); ack = 1'b0;
    mask = 4'hF;
    repeat (10) step();

    // Overflow, ovf_clr, and re-arm coinciding with the ack
    src = 4'b0010; step();
    src = 4'b0000; step();
    chk("t4_id", 32'(irq_id), 32'd1);
    src = 4'b0010; step();
    chk("t4_ovf", 32'(overflow), 32'h2);
    src = 4'b0000; ack = 1'b1; step(); ack = 1'b0;
    chk("t4_pend", 32'(pending), 32'h0);
    chk("t4_ovf_kept", 32'(overflow), 32'h2);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("t4_ovf_clr", 32'(overflow), 32'h0);
    repeat (10) step();
    src = 4'b0010; step();
    src = 4'b0000; step();
    chk("t4_irq", 32'(irq), 32'd1);
    src = 4'b0010; ack = 1'b1; step();
    src = 4'b0000; ack = 1'b0;
    chk("t4_rearm", 32'(pending), 32'h2);
    chk("t4_rearm_ovf", 32'(overflow), 32'h0);
    chk("t4_led", 32'(led_on), 32'h2);
    wait_irq(n);
    chk("t4_gap", 32'(n), 32'd9);
    chk("t4_id2", 32'(irq_id), 32'd1);
    ack = 1'b1; step(); ack = 1'b0;
    repeat (10) step();

    // Reset during ASSERT with source 3 held high
    src = 4'b1000; step(); step();
    chk("t5_irq", 32'(irq), 32'd1);
    chk("t5_id", 32'(irq_id), 32'd3);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t5_irq0", 32'(irq), 32'd0);
    chk("t5_id0", 32'(irq_id), 32'd0);
    chk("t5_pend0", 32'(pending), 32'd0);
    chk("t5_led0", 32'(led_on), 32'd0);
    repeat (3) step();
    chk("t5_noevt", 32'(pending), 32'd0);
    src = 4'b0000; step();
    src = 4'b1000; step();
    chk("t5_evt", 32'(pending), 32'h8);
    step();
    chk("t5_id3", 32'(irq_id), 32'd3);
    ack = 1'b1; step(); ack = 1'b0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/push_irq_ctrl.md
# push_irq_ctrl

Interrupt controller that shares a single CPU interrupt line among `NUM_SRC` debounced push-button sources. It sits between the per-button debounce instances (their `intr_src` outputs) and the processor interrupt input. It latches each source edge as pending, grants pending sources in round-robin order, and holds `irq` with the granted source id until software acknowledges. It also drives the board LEDs with the last serviced source.

## Interface
Parameters:
- `NUM_SRC`, 4, number of debounced sources (2..16)
- `ID_W`, 2, width of `irq_id`; must equal clog2(`NUM_SRC`)
- `HOLDOFF`, 8, idle cycles forced after each acknowledge before the next grant (0..255)

Ports:
- `S_AXI_ACLK`  in  1  system clock; all logic on its rising edge
- `S_AXI_ARESET`  in  1  synchronous reset, active-high
- `intr_src`  in  NUM_SRC  debounced source lines; level or pulse, rising edge counts as an event
- `mask`  in  NUM_SRC  1 = source enabled for grant; masked sources still latch pending
- `irq_ack`  in  1  one-cycle acknowledge from CPU for the current grant
- `ovf_clr`  in  1  clears all sticky `overflow` bits
- `irq`  out  1  interrupt request to CPU
- `irq_id`  out  ID_W  index of granted source; valid while `irq`=1
- `pending`  out  NUM_SRC  latched, not-yet-serviced events
- `overflow`  out  NUM_SRC  sticky: an event arrived while that source was already pending
- `led_on`  out  4  one-hot of last acknowledged source id (bits above 3 not shown)

## Operation
- Edge detect: `prev` register samples `intr_src` every cycle. `rise = intr_src & ~prev`.
- Pending: `pending[i]` is set on `rise[i]` and cleared on ack of grant `i`.
  - Ack of `i` coinciding with `rise[i]`: pending stays 1. No overflow.
  - `rise[i]` while `pending[i]`=1 with no ack of `i`: `overflow[i]` set. `ovf_clr` wins over a same-cycle set.
- FSM states:
  - IDLE: `irq`=0. If `pending & mask` is nonzero, choose the first set bit searching upward from `ptr+1` modulo `NUM_SRC`. Register the choice into `irq_id`, set `irq`=1, and go to ASSERT.
  - ASSERT: `irq`=1 and `irq_id` held stable.
    - Masking the granted source does not retract `irq`.
    - On `irq_ack`: clear `pending[irq_id]` (subject to the re-arm rule), set `ptr`=`irq_id`, set `led_on`=one-hot(`irq_id`), set `irq`=0, load the holdoff counter with `HOLDOFF`, and go to HOLDOFF. If `HOLDOFF`=0, go to IDLE instead.
  - HOLDOFF: `irq`=0. Counter decrements each cycle. At 1, go to IDLE.
- `irq_ack` outside ASSERT is ignored.
- Reset values:
  - `prev`=all ones, so a line held high through reset produces no event.
  - `ptr`=`NUM_SRC`-1, so source 0 has first priority.
  - `pending`=0, `overflow`=0, `irq`=0, `irq_id`=0, `led_on`=0, state=IDLE.
- Reset mid-operation (any state) returns to these values on the next edge. Events in flight are discarded.

## Timing
- Edge k first samples `intr_src[i]`=1 after a 0: `pending[i]`=1 after edge k.
- If IDLE and `mask[i]`=1, `irq`=1 with `irq_id`=i after edge k+1. Event-to-irq latency is 2 cycles.
- `irq_ack` sampled at edge a: `irq`=0, `pending` and `led_on` updated after edge a.
- Earliest next `irq`=1 is after edge a+`HOLDOFF`+1; with `HOLDOFF`=0, after edge a+1.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset, then pulse `intr_src[2]` for one cycle with `mask`=4'hF → `pending`=4'b0100 one edge later; `irq`=1, `irq_id`=2 one edge after that; `irq_ack` → `irq`=0, `pending`=0, `led_on`=4'b0100.
- Pulse all four sources in the same cycle, ack each grant immediately, `HOLDOFF`=8 → grant order 0,1,2,3; consecutive grants spaced exactly 9 cycles after each ack.
- `pending`=4'b0011 with `mask`=4'b0001 → only id 0 granted. After its ack, `irq` stays 0 with `pending`=4'b0010. Setting `mask`=4'b0011 → id 1 granted 1 cycle later.
- Second rising edge on source 1 while pending, before ack → `overflow`=4'b0010 stays after ack. `ovf_clr` → `overflow`=0. Rise coinciding with the ack of 1 → `pending[1]` remains 1 and no overflow.
- Assert `S_AXI_ARESET` during ASSERT with `intr_src[3]` held high → all outputs 0 after the edge. After release, no event is generated on source 3 until it falls and rises again.
